// File: rtl/instr_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// instr_mem_responder_pkg
// Shared definitions for the instruction-memory fetch responder:
//   - state_t            : responder FSM state encoding
//   - CMD_FETCH_DEFAULT  : command byte that opens a fetch request
//   - REPLY_BYTES_*      : number of UART bytes in one reply
// Build option: define RESP_CHECKSUM_EN to append an XOR checksum byte
// to every reply (adds the SEND_CK/WAIT_CK states).
// ---------------------------------------------------------------------------
package instr_mem_responder_pkg;

    localparam logic [7:0] CMD_FETCH_DEFAULT = 8'h03;

    localparam int REPLY_BYTES_PLAIN    = 2;
    localparam int REPLY_BYTES_CHECKSUM = 3;

`ifdef RESP_CHECKSUM_EN
    localparam int REPLY_BYTES = REPLY_BYTES_CHECKSUM;
`else
    localparam int REPLY_BYTES = REPLY_BYTES_PLAIN;
`endif

    typedef enum logic [3:0] {
        IDLE,
        GET_ADDR,
        MEM_RD,
        SEND_HI,
        WAIT_HI,
        SEND_LO,
        WAIT_LO
`ifdef RESP_CHECKSUM_EN
        ,
        SEND_CK,
        WAIT_CK
`endif
    } state_t;

endpackage

// File: rtl/instr_mem_responder_if.sv
// ---------------------------------------------------------------------------
// instr_mem_responder_if
// Bundles the UART byte handshake and the instruction-memory read port
// seen by the responder.
//   rx_done/rx_data   : received byte strobe and data (from UART)
//   tx_en/tx_data     : transmit start strobe and byte (to UART)
//   tx_done           : transmit complete strobe (from UART)
//   mem_addr          : read address (to memory)
//   mem_rdata         : read data, valid one cycle after mem_addr (from memory)
// Modports:
//   slave  : the responder
//   master : the environment (UART + memory)
// ---------------------------------------------------------------------------
interface instr_mem_responder_if;

    logic        rx_done;
    logic [7:0]  rx_data;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata;

    modport slave (
        input  rx_done,
        input  rx_data,
        input  tx_done,
        input  mem_rdata,
        output tx_en,
        output tx_data,
        output mem_addr
    );

    modport master (
        output rx_done,
        output rx_data,
        output tx_done,
        output mem_rdata,
        input  tx_en,
        input  tx_data,
        input  mem_addr
    );

endinterface

// File: rtl/instr_mem_responder.sv
// ---------------------------------------------------------------------------
// instr_mem_responder
// Serves instruction fetches requested over a UART byte link: a CMD_FETCH
// byte followed by an address byte causes one 16-bit memory read, and the
// word is returned high byte first, then low byte (then an XOR checksum
// byte when RESP_CHECKSUM_EN is defined). Only one byte is ever in flight.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous, active-low reset
//   bus        : UART + memory handshake (instr_mem_responder_if.slave)
//   busy       : high from command accept until the last reply byte is done
//   req_count  : number of completed fetches, wraps 255 -> 0
//   cmd_err    : sticky flag, set by an unknown command byte in IDLE
//
// Parameter:
//   CMD_FETCH  : command byte that opens a fetch request
//
// Build option: RESP_CHECKSUM_EN (default undefined = 2-byte replies).
// ---------------------------------------------------------------------------
module instr_mem_responder
    import instr_mem_responder_pkg::*;
#(
    parameter logic [7:0] CMD_FETCH = CMD_FETCH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    instr_mem_responder_if.slave        bus,
    output logic                        busy,
    output logic [7:0]                  req_count,
    output logic                        cmd_err
);

    state_t      state;
    state_t      state_next;

    logic [7:0]  addr;
    logic [15:0] word;
    logic [7:0]  tx_byte;
    logic [7:0]  tx_byte_next;

    logic        addr_load;
    logic        word_load;
    logic        err_set;
    logic        count_inc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            addr      <= '0;
            word      <= '0;
            tx_byte   <= '0;
            req_count <= '0;
            cmd_err   <= 1'b0;
        end else begin
            state   <= state_next;
            tx_byte <= tx_byte_next;
            if (addr_load) begin
                addr <= bus.rx_data;
            end
            if (word_load) begin
                word <= bus.mem_rdata;
            end
            if (count_inc) begin
                req_count <= req_count + 8'd1;
            end
            if (err_set) begin
                cmd_err <= 1'b1;
            end
        end
    end

    // The transmit byte is registered and loaded on the transition into each
    // SEND_* state, so it is already stable when tx_en rises and stays put
    // through the matching WAIT_* state.
    always_comb begin
        state_next   = state;
        tx_byte_next = tx_byte;
        addr_load    = 1'b0;
        word_load    = 1'b0;
        err_set      = 1'b0;
        count_inc    = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.rx_done) begin
                    if (bus.rx_data == CMD_FETCH) begin
                        state_next = GET_ADDR;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            GET_ADDR: begin
                if (bus.rx_done) begin
                    addr_load  = 1'b1;
                    state_next = MEM_RD;
                end
            end
            MEM_RD: begin
                // word is not yet loaded here, so the high byte comes
                // straight from the memory read data.
                word_load    = 1'b1;
                tx_byte_next = bus.mem_rdata[15:8];
                state_next   = SEND_HI;
            end
            SEND_HI: begin
                state_next = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.tx_done) begin
                    tx_byte_next = word[7:0];
                    state_next   = SEND_LO;
                end
            end
            SEND_LO: begin
                state_next = WAIT_LO;
            end
            WAIT_LO: begin
                if (bus.tx_done) begin
`ifdef RESP_CHECKSUM_EN
                    tx_byte_next = word[15:8] ^ word[7:0];
                    state_next   = SEND_CK;
`else
                    count_inc  = 1'b1;
                    state_next = IDLE;
`endif
                end
            end
`ifdef RESP_CHECKSUM_EN
            SEND_CK: begin
                state_next = WAIT_CK;
            end
            WAIT_CK: begin
                if (bus.tx_done) begin
                    count_inc  = 1'b1;
                    state_next = IDLE;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // tx_en is decoded from the state so it pulses exactly once per SEND_*
    // visit; each SEND_* is only reached after the previous byte's tx_done.
    always_comb begin
        bus.tx_en = 1'b0;
        unique case (state)
            SEND_HI,
`ifdef RESP_CHECKSUM_EN
            SEND_CK,
`endif
            SEND_LO: bus.tx_en = 1'b1;
            default: bus.tx_en = 1'b0;
        endcase
    end

    assign busy         = (state != IDLE);
    assign bus.tx_data  = tx_byte;
    assign bus.mem_addr = addr;

endmodule

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-003 SHALL have ports: rx_done  input  1  one-cycle pulse, UART byte received; rx_data  input  8  received byte, valid while rx_done=1.
REQ-004 SHALL have ports: tx_en  output  1  one-cycle pulse, start UART transmit; tx_data  output  8  byte to send, held stable from tx_en until tx_done; tx_done  input  1  one-cycle pulse, byte fully sent.
REQ-005 SHALL have ports: mem_addr  output  8  instruction memory read address; mem_rdata  input  16  read data, valid exactly one cycle after mem_addr is presented.
REQ-006 SHALL have ports: busy  output  1  high from command accept until last reply byte done; req_count  output  8  served fetches, wraps 255->0; cmd_err  output  1  sticky, set by an unknown command byte.
REQ-007 SHALL have parameter: CMD_FETCH, default 8'h03, command byte opening a fetch request.

Function
REQ-008 SHALL implement states IDLE, GET_ADDR, MEM_RD, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, SEND_CK, WAIT_CK.
REQ-009 IDLE: rx_done with rx_data==CMD_FETCH -> GET_ADDR, busy=1; rx_done with other value -> stay IDLE, set cmd_err.
REQ-010 GET_ADDR: on rx_done, latch rx_data into mem_addr -> MEM_RD; no timeout.
REQ-011 MEM_RD: lasts exactly one cycle; at its end latch mem_rdata into an internal 16-bit word register -> SEND_HI.
REQ-012 SEND_HI: tx_en=1 for one cycle, tx_data=word[15:8] -> WAIT_HI; WAIT_HI waits for tx_done -> SEND_LO.
REQ-013 SEND_LO/WAIT_LO: same handshake with word[7:0]; on tx_done -> SEND_CK if checksum enabled (REQ-020), else IDLE.
REQ-014 On return to IDLE after the final tx_done: busy=0 and req_count increments by 1, both in the same cycle.
REQ-015 rx_done in any state other than IDLE and GET_ADDR SHALL be ignored; it SHALL NOT set cmd_err.
REQ-016 tx_done arriving in any state other than WAIT_* SHALL be ignored.
REQ-017 tx_en SHALL never be asserted while a previous byte is outstanding: at most one byte in flight.
REQ-018 Latency: the SEND_HI tx_en pulse SHALL occur exactly 2 cycles after the rx_done cycle that delivered the address byte.

Reset
REQ-019 While reset==0 at a clk edge: state=IDLE, tx_en=0, tx_data=0, mem_addr=0, busy=0, req_count=0, cmd_err=0, word=0; reset mid-transaction abandons the reply with no further tx_en pulses.

Configuration
REQ-020 Macro RESP_CHECKSUM_EN defined: after WAIT_LO, SEND_CK sends word[15:8]^word[7:0], then WAIT_CK waits for tx_done -> IDLE; undefined: SEND_CK/WAIT_CK are not built and each reply is exactly 2 bytes.

Structure
REQ-021 A shared package SHALL hold the state enumeration, CMD_FETCH default and the reply byte count constants (2, and 3 with checksum).
REQ-022 The block SHALL be one module with no sub-modules; the UART and the memory array are external.

Verification
REQ-023 rx 8'h03, 8'h10; mem[0x10]=16'hA5C3 -> mem_addr=8'h10, tx bytes A5 then C3, req_count 0->1, busy low after second tx_done.
REQ-024 RESP_CHECKSUM_EN defined, same stimulus -> tx bytes A5, C3, 66; exactly three tx_en pulses.
REQ-025 rx 8'h7F in IDLE -> cmd_err=1, no tx_en, state stays IDLE; then a valid fetch completes normally with cmd_err still 1.
REQ-026 Extra rx byte 8'h03 during WAIT_HI -> ignored: reply completes unchanged, no second fetch, cmd_err stays 0.
REQ-027 Reset asserted in WAIT_LO -> all outputs at reset values next cycle, no further tx_en even if tx_done then arrives; a following fetch of 8'hFF works.
REQ-028 256 back-to-back fetches -> req_count wraps to 8'h00, every reply matches memory contents.
